// File: rtl/sti_rx.sv
// sti_rx: serial-to-parallel receiver for the STI link.
// Reassembles 8/16/24/32-bit frames from a qualified serial stream, writes each
// completed byte to the 256-byte pixel memory, and zero-fills the remainder of
// that memory once the transmitter signals that no more frames will follow.
module sti_rx (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_load,
   input  logic [1:0]  cfg_length,
   input  logic        cfg_msb,
   input  logic        si_data,
   input  logic        si_valid,
   input  logic        rx_end,
   output logic [31:0] po_data,
   output logic        po_valid,
   output logic        po_err,
   output logic        pixel_wr,
   output logic [7:0]  pixel_addr,
   output logic [7:0]  pixel_dataout,
   output logic        pixel_finish
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      FILL   = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t      state;
   logic [1:0]  len_q;     // latched frame length code
   logic        msb_q;     // latched bit order
   logic [4:0]  cnt;       // index of the bit sampled on the next valid cycle
   logic [31:0] word_q;    // frame under assembly
   logic [7:0]  byte_q;    // byte under assembly
   logic        full;      // address 255 has been written at least once

   // A config load in IDLE takes effect for a frame starting on the same edge.
   logic [1:0]  len_eff;
   logic        msb_eff;
   logic [4:0]  bit_idx;
   logic [31:0] word_base;
   logic [31:0] word_nxt;
   logic [7:0]  byte_nxt;
   logic        byte_done;
   logic        frame_last;
   logic [7:0]  addr_nxt;
   logic        full_eff;

   assign len_eff   = (state == IDLE && cfg_load) ? cfg_length : len_q;
   assign msb_eff   = (state == IDLE && cfg_load) ? cfg_msb    : msb_q;

   // The first bit of a frame is always index 0 and starts from a cleared word.
   assign bit_idx   = (state == IDLE) ? 5'd0  : cnt;
   assign word_base = (state == IDLE) ? 32'd0 : word_q;

   // Last index of a frame is 8*(len+1)-1, i.e. {len, 3'b111}.
   assign byte_done  = (bit_idx[2:0] == 3'd7);
   assign frame_last = (bit_idx == {len_eff, 3'b111});

   // Address a write issued on this edge will target (the pending write, if
   // any, advances the address on the same edge).
   assign addr_nxt  = pixel_wr ? (pixel_addr + 8'd1) : pixel_addr;

   // A write to 255 completing on this edge counts as already full.
   assign full_eff  = full || (pixel_wr && (pixel_addr == 8'hFF));

   // Next word/byte values for the bit being sampled this cycle.
   always_comb begin
      word_nxt = word_base;
      if (msb_eff) begin
         word_nxt = {word_base[30:0], si_data};
      end else begin
         word_nxt[bit_idx] = si_data;
      end
      if (msb_eff) begin
         byte_nxt = {byte_q[6:0], si_data};
      end else begin
         byte_nxt = {si_data, byte_q[7:1]};
      end
   end

   // Receive/fill state machine with registered outputs and memory address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         len_q         <= 2'd0;
         msb_q         <= 1'b0;
         cnt           <= 5'd0;
         word_q        <= 32'd0;
         byte_q        <= 8'd0;
         full          <= 1'b0;
         po_data       <= 32'd0;
         po_valid      <= 1'b0;
         po_err        <= 1'b0;
         pixel_wr      <= 1'b0;
         pixel_addr    <= 8'd0;
         pixel_dataout <= 8'd0;
         pixel_finish  <= 1'b0;
      end else begin
         po_valid      <= 1'b0;
         po_err        <= 1'b0;
         pixel_wr      <= 1'b0;
         pixel_dataout <= 8'd0;

         // The address holds during the write cycle and advances afterwards.
         if (pixel_wr) begin
            pixel_addr <= pixel_addr + 8'd1;
            if (pixel_addr == 8'hFF) begin
               full <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (cfg_load) begin
                  len_q <= cfg_length;
                  msb_q <= cfg_msb;
               end
               if (si_valid) begin
                  word_q <= word_nxt;
                  byte_q <= byte_nxt;
                  cnt    <= 5'd1;
                  state  <= RECV;
               end else if (rx_end) begin
                  state  <= FILL;
               end
            end

            RECV: begin
               if (si_valid) begin
                  word_q <= word_nxt;
                  byte_q <= byte_nxt;
                  cnt    <= cnt + 5'd1;
                  if (byte_done) begin
                     pixel_wr      <= 1'b1;
                     pixel_dataout <= byte_nxt;
                  end
                  if (frame_last) begin
                     po_data  <= word_nxt;
                     po_valid <= 1'b1;
                     cnt      <= 5'd0;
                     state    <= IDLE;
                  end
               end else begin
                  // Dropped qualifier: discard the partial frame, keep po_data.
                  po_err <= 1'b1;
                  cnt    <= 5'd0;
                  state  <= IDLE;
               end
            end

            FILL: begin
               if (full_eff) begin
                  pixel_finish <= 1'b1;
                  state        <= FINISH;
               end else begin
                  pixel_wr      <= 1'b1;
                  pixel_dataout <= 8'h00;
                  if (addr_nxt == 8'hFF) begin
                     state <= FINISH;
                  end
               end
            end

            FINISH: begin
               pixel_finish <= 1'b1;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sti_rx.sv
// Testbench for sti_rx: table of single frames plus hand-written sequences for
// back-to-back frames, abort, end-and-fill, full-memory fill and async reset.
module tb_sti_rx;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_load = 1'b0;
   logic [1:0]  cfg_length = 2'd0;
   logic        cfg_msb = 1'b0;
   logic        si_data = 1'b0;
   logic        si_valid = 1'b0;
   logic        rx_end = 1'b0;
   logic [31:0] po_data;
   logic        po_valid;
   logic        po_err;
   logic        pixel_wr;
   logic [7:0]  pixel_addr;
   logic [7:0]  pixel_dataout;
   logic        pixel_finish;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  exp_addr = 8'd0;

   sti_rx dut (
      .clk          (clk),
      .reset        (reset),
      .cfg_load     (cfg_load),
      .cfg_length   (cfg_length),
      .cfg_msb      (cfg_msb),
      .si_data      (si_data),
      .si_valid     (si_valid),
      .rx_end       (rx_end),
      .po_data      (po_data),
      .po_valid     (po_valid),
      .po_err       (po_err),
      .pixel_wr     (pixel_wr),
      .pixel_addr   (pixel_addr),
      .pixel_dataout(pixel_dataout),
      .pixel_finish (pixel_finish)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          nbits;
      logic        msb;
      logic        load_first;
      logic [31:0] data;
      logic [31:0] exp_po;
      logic [31:0] exp_bytes;  // write order, first byte in the top 8 of nbits
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_po_data"},  po_data, 32'd0);
      chk({tag, "_po_valid"}, po_valid, 1'b0);
      chk({tag, "_po_err"},   po_err, 1'b0);
      chk({tag, "_wr"},       pixel_wr, 1'b0);
      chk({tag, "_addr"},     pixel_addr, 8'd0);
      chk({tag, "_dout"},     pixel_dataout, 8'd0);
      chk({tag, "_finish"},   pixel_finish, 1'b0);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check_all_zero("rst");
      step();
      step();
      reset    = 1'b1;
      exp_addr = 8'd0;
   endtask

   task automatic load_cfg(input logic [1:0] len, input logic msb);
      cfg_load   = 1'b1;
      cfg_length = len;
      cfg_msb    = msb;
      si_valid   = 1'b0;
      step();
      cfg_load   = 1'b0;
   endtask

   task automatic idle_step();
      si_valid = 1'b0;
      si_data  = 1'b0;
      step();
      chk("idle_po_valid", po_valid, 1'b0);
      chk("idle_wr", pixel_wr, 1'b0);
      chk("idle_dout", pixel_dataout, 8'd0);
   endtask

   // Sends one frame bit by bit and checks write strobes and po_valid timing.
   task automatic send_frame(input int nbits, input logic msb, input logic load_first,
                             input logic [31:0] data, input logic [31:0] exp_po,
                             input logic [31:0] exp_bytes);
      int k;
      int base;
      k = 0;
      for (int i = 0; i < nbits; i++) begin
         si_valid = 1'b1;
         si_data  = msb ? data[nbits-1-i] : data[i];
         if (load_first && i == 0) begin
            cfg_load   = 1'b1;
            cfg_length = 2'(nbits/8 - 1);
            cfg_msb    = msb;
         end
         step();
         cfg_load = 1'b0;
         if (i % 8 == 7) begin
            base = nbits - 1 - 8*k;
            chk("byte_wr", pixel_wr, 1'b1);
            chk("byte_data", pixel_dataout, exp_bytes[base -: 8]);
            chk("byte_addr", pixel_addr, exp_addr);
            exp_addr = exp_addr + 8'd1;
            k++;
         end else begin
            chk("no_wr", pixel_wr, 1'b0);
         end
         if (i == nbits - 1) begin
            chk("po_valid", po_valid, 1'b1);
            chk("po_data", po_data, exp_po);
         end else begin
            chk("po_valid_low", po_valid, 1'b0);
         end
         chk("po_err_low", po_err, 1'b0);
      end
   endtask

   initial begin
      int  nw;
      int  done_c;
      logic done;
      logic prev_wr255;
      logic [11:0] abort_bits;
      logic [7:0] kk;

      tbl[0] = '{8,  1'b1, 1'b0, 32'h000000A5, 32'h000000A5, 32'h000000A5};
      tbl[1] = '{16, 1'b0, 1'b0, 32'h00001234, 32'h00001234, 32'h00003412};
      tbl[2] = '{24, 1'b1, 1'b1, 32'h00123456, 32'h00123456, 32'h00123456};
      tbl[3] = '{32, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0DF0FECA};
      tbl[4] = '{8,  1'b0, 1'b0, 32'h00000081, 32'h00000081, 32'h00000081};
      tbl[5] = '{32, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};

      #2;
      apply_reset();
      step();
      check_all_zero("post_rst");

      // Single frames from the table, addresses accumulate from 0.
      for (int v = 0; v < 6; v++) begin
         if (!tbl[v].load_first) begin
            load_cfg(2'(tbl[v].nbits/8 - 1), tbl[v].msb);
         end
         send_frame(tbl[v].nbits, tbl[v].msb, tbl[v].load_first,
                    tbl[v].data, tbl[v].exp_po, tbl[v].exp_bytes);
         idle_step();
      end
      chk("tbl_addr_after", pixel_addr, 8'd15);

      // Back-to-back 32-bit MSB-first frames, si_valid held high throughout.
      apply_reset();
      load_cfg(2'd3, 1'b1);
      send_frame(32, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
      send_frame(32, 1'b1, 1'b0, 32'h01020304, 32'h01020304, 32'h01020304);
      idle_step();
      chk("b2b_addr", pixel_addr, 8'd8);

      // Abort a 24-bit frame after 12 bits.
      apply_reset();
      load_cfg(2'd2, 1'b1);
      abort_bits = 12'hABC;
      for (int i = 0; i < 12; i++) begin
         si_valid = 1'b1;
         si_data  = abort_bits[11-i];
         step();
         if (i == 7) begin
            chk("abort_wr", pixel_wr, 1'b1);
            chk("abort_data", pixel_dataout, 8'hAB);
            chk("abort_addr", pixel_addr, 8'd0);
            exp_addr = exp_addr + 8'd1;
         end else begin
            chk("abort_no_wr", pixel_wr, 1'b0);
         end
      end
      si_valid = 1'b0;
      step();
      chk("abort_err", po_err, 1'b1);
      chk("abort_po_valid", po_valid, 1'b0);
      chk("abort_po_data", po_data, 32'd0);
      step();
      chk("abort_err_pulse", po_err, 1'b0);
      load_cfg(2'd0, 1'b1);
      send_frame(8, 1'b1, 1'b0, 32'h3C, 32'h3C, 32'h3C);
      idle_step();

      // Three 8-bit frames then rx_end: zero fill of addresses 3..255.
      apply_reset();
      load_cfg(2'd0, 1'b1);
      send_frame(8, 1'b1, 1'b0, 32'h11, 32'h11, 32'h11);
      send_frame(8, 1'b1, 1'b0, 32'h22, 32'h22, 32'h22);
      send_frame(8, 1'b1, 1'b0, 32'h33, 32'h33, 32'h33);
      si_valid = 1'b0;
      rx_end   = 1'b1;
      step();
      rx_end   = 1'b0;
      chk("fill_entry_wr", pixel_wr, 1'b0);
      nw = 0;
      done = 1'b0;
      done_c = -1;
      prev_wr255 = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         step();
         if (pixel_finish) begin
            done   = 1'b1;
            done_c = c;
            chk("finish_after_255", prev_wr255, 1'b1);
            chk("finish_no_wr", pixel_wr, 1'b0);
         end else if (pixel_wr) begin
            chk("fill_addr", pixel_addr, exp_addr);
            chk("fill_data", pixel_dataout, 8'h00);
            prev_wr255 = (exp_addr == 8'hFF);
            exp_addr   = exp_addr + 8'd1;
            nw++;
         end else begin
            prev_wr255 = 1'b0;
         end
      end
      chk("fill_done", done, 1'b1);
      chk("fill_writes", nw, 253);
      chk("fill_cycles", done_c, 253);
      for (int i = 0; i < 12; i++) begin
         si_valid = 1'b1;
         si_data  = 1'b1;
         step();
         chk("fin_hold", pixel_finish, 1'b1);
         chk("fin_no_wr", pixel_wr, 1'b0);
         chk("fin_no_valid", po_valid, 1'b0);
      end
      si_valid = 1'b0;

      // Fill all 256 bytes, wrap one more byte to 0, then rx_end finishes at once.
      apply_reset();
      load_cfg(2'd3, 1'b1);
      for (int f = 0; f < 64; f++) begin
         kk = 8'(f);
         send_frame(32, 1'b1, 1'b0, {4{kk}}, {4{kk}}, {4{kk}});
      end
      idle_step();
      chk("full_wrap_addr", pixel_addr, 8'd0);
      load_cfg(2'd0, 1'b1);
      send_frame(8, 1'b1, 1'b0, 32'h77, 32'h77, 32'h77);
      si_valid = 1'b0;
      rx_end   = 1'b1;
      step();
      rx_end   = 1'b0;
      chk("full_fill_finish_low", pixel_finish, 1'b0);
      step();
      chk("full_fill_no_wr", pixel_wr, 1'b0);
      chk("full_fill_finish", pixel_finish, 1'b1);
      step();
      chk("full_fill_hold", pixel_finish, 1'b1);
      chk("full_fill_no_wr2", pixel_wr, 1'b0);

      // Async reset during FILL; config returns to 8-bit LSB-first, addr 0.
      apply_reset();
      load_cfg(2'd0, 1'b1);
      send_frame(8, 1'b1, 1'b0, 32'h99, 32'h99, 32'h99);
      idle_step();
      rx_end = 1'b1;
      step();
      rx_end = 1'b0;
      step();
      step();
      chk("midfill_wr", pixel_wr, 1'b1);
      chk("midfill_addr", pixel_addr, 8'd2);
      apply_reset();
      send_frame(8, 1'b0, 1'b0, 32'h5A, 32'h5A, 32'h5A);
      idle_step();
      chk("post_rst_finish", pixel_finish, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sti_rx.md
# sti_rx

Serial-to-parallel receiver for the STI link: samples a serial bit stream (si_data qualified by si_valid) and reassembles frames of 8/16/24/32 bits into a parallel word. It also writes every completed byte to the 256-byte pixel memory. After the last frame it zero-fills the remaining memory and raises a finish flag. It sits at the far end of the STI serial link, opposite the STI transmitter/DAC block.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_load  in  1  latches cfg_length and cfg_msb; honoured only in IDLE.
- cfg_length  in  2  frame length: 0 = 8, 1 = 16, 2 = 24, 3 = 32 bits.
- cfg_msb  in  1  1 = first received bit is the MSB of the frame; 0 = first bit is the LSB.
- si_data  in  1  serial data bit.
- si_valid  in  1  si_data is valid this cycle; must stay high for the whole frame.
- rx_end  in  1  no further frames; sampled only in IDLE.
- po_data  out  32  assembled frame, right-aligned, upper bits zero; reset 0.
- po_valid  out  1  one-cycle pulse, po_data is new; reset 0.
- po_err  out  1  one-cycle pulse, frame aborted; reset 0.
- pixel_wr  out  1  one-cycle memory write strobe; reset 0.
- pixel_addr  out  8  write address; reset 0.
- pixel_dataout  out  8  write data; reset 0.
- pixel_finish  out  1  level; memory complete; reset 0.

## Operation
**States:** IDLE, RECV, FILL, FINISH. Reset enters IDLE and clears every register, including the latched config (length 0, msb 0), the bit counter, the byte shift register, and the `full` flag.

**IDLE**
- cfg_load=1 latches cfg_length and cfg_msb.
- si_valid=1 samples that bit as bit index 0 of a new frame and moves to RECV.
- si_valid has priority over rx_end.
- rx_end=1 with si_valid=0 moves to FILL.
- If cfg_load and si_valid are both high, the newly loaded config applies to this frame.

**RECV**
- Each cycle with si_valid=1 shifts one bit in; the 5-bit counter counts 0 .. L-1, where L = 8·(cfg_length+1).
- Word assembly:
  - msb=1: w ← {w[30:0], si_data}.
  - msb=0: w[cnt] ← si_data.
  - In both cases the word is cleared at frame start.
- Byte assembly:
  - msb=1: b ← {b[6:0], si_data}.
  - msb=0: b ← {si_data, b[7:1]}.
  - The byte written for each group of 8 bits therefore equals the corresponding byte of po_data.
- When cnt[2:0]=7, the byte is written to memory (see Timing).
- When cnt = L-1, the frame completes and the block returns to IDLE.
- si_valid=0 in RECV aborts the frame:
  - po_err pulses; po_data is unchanged; the block returns to IDLE.
  - Bytes already written stay written; pixel_addr is not rewound.

**FILL**
- Writes 8'h00 at pixel_addr each cycle, incrementing the address, until address 255 has been written; then moves to FINISH.
- If `full` is already set on entry, goes directly to FINISH with no writes.

**FINISH**
- pixel_finish=1 is held until reset; all other inputs are ignored.

**Address rules**
- pixel_addr increments by 1 (mod 256) after every write.
- `full` is set when address 255 is written.
- Writes past 256 bytes wrap the address to 0; `full` stays set.

## Timing
- An input bit is sampled on the edge where si_valid=1.
- po_data/po_valid update on the edge that samples the last bit of the frame, so they are visible the cycle after the last bit (latency 1).
- pixel_wr=1 and pixel_dataout are registered on the edge that samples the 8th bit of a byte. pixel_addr holds the target address during that cycle and increments on the next edge.
- Back-to-back frames: si_valid may stay high continuously. The first bit after a frame completes is taken in IDLE with no gap, so there are no dead cycles between frames.
- The next frame's first bit may coincide with the previous frame's po_valid pulse.
- pixel_dataout returns to 0 when pixel_wr=0.
- FILL writes one byte per cycle, with pixel_wr held high for consecutive cycles.
- pixel_finish rises the cycle after the address-255 write (or the cycle after entering FILL when `full` is set).
- Asynchronous reset mid-frame or mid-FILL immediately clears all outputs to their reset values. The partial frame is lost.

## Test plan
- **8-bit MSB-first:** cfg_length=0, msb=1, bits 1,0,1,0,0,1,0,1 → po_data=32'h000000A5 and po_valid one cycle after the last bit; one write: addr 0, data 8'hA5.
- **16-bit LSB-first:** word 16'h1234 sent LSB first → po_data=32'h00001234; writes at addr 0 = 8'h34 and addr 1 = 8'h12, each pulsed after bits 8 and 16.
- **32-bit MSB-first back-to-back:** 32'hDEADBEEF then 32'h01020304 with si_valid continuously high → two po_valid pulses 32 cycles apart; bytes DE, AD, BE, EF, 01, 02, 03, 04 written at addr 0–7.
- **Abort:** 24-bit frame with si_valid dropped after 12 bits → po_err pulses once; po_valid stays 0; one byte written at addr 0; the next frame starts at addr 1.
- **End and fill:** three 8-bit frames then rx_end=1 → 253 zero writes at addr 3..255, then pixel_finish=1 held; si_valid is ignored afterwards.
- **Reset:** reset driven low mid-FILL → all outputs 0 the same cycle and state IDLE; after release, the first frame writes at addr 0.
